// File: rtl/cg_tape_pkg.sv
// Shared cassette-playback definitions: bit-cell timing defaults and the player state encoding.
package cg_tape_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } tape_state_t;

  // Bit-cell timing in CPU cycles; a cell spans counts 0..PERIOD inclusive.
  localparam logic [11:0] SYNC_END_DEF = 12'h200;
  localparam logic [11:0] DATA_AT_DEF  = 12'h6FF;
  localparam logic [11:0] DATA_END_DEF = 12'h8FF;
  localparam logic [11:0] PERIOD_DEF   = 12'hE08;

  localparam logic [2:0]  BITPTR_MSB   = 3'd7;

  function automatic logic byte_bit(input logic [7:0] b, input logic [2:0] idx);
    return b[idx];
  endfunction

endpackage

// File: rtl/cas_player.sv
// CAS image player: streams bytes MSB first from external RAM as sync + data pulses on the port $FF input bit.
module cas_player
  import cg_tape_pkg::*;
#(
  parameter logic [11:0] SYNC_END = SYNC_END_DEF,
  parameter logic [11:0] DATA_AT  = DATA_AT_DEF,
  parameter logic [11:0] DATA_END = DATA_END_DEF,
  parameter logic [11:0] PERIOD   = PERIOD_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        play,
  input  logic        port_wr,
  input  logic [2:0]  port_d,
  input  logic        port_rd,
  input  logic [16:0] tape_end,
  output logic [16:0] ram_a,
  input  logic [7:0]  ram_q,
  output logic        latch,
  output logic        motor,
  output logic [1:0]  snd,
  output logic        busy,
  output logic        done,
  output tape_state_t state
);

  logic [11:0] cnt;
  logic [2:0]  bitptr;
  logic        bitval;
  logic [1:0]  snd_wr;

  // port_wr / port_rd are single-ce strobes: they act only on a clock with ce=1
  // and carry no handshake back; every other input is likewise sampled only under ce.
  logic wr_stb, rd_stb;
  logic motor_on_edge, motor_off_edge;
  logic past_end, sync_win, data_win;
  logic latch_set, latch_clr;

  assign wr_stb         = ce & port_wr;
  assign rd_stb         = ce & port_rd;
  assign motor_on_edge  = wr_stb &  port_d[2] & ~motor;
  assign motor_off_edge = wr_stb & ~port_d[2] &  motor;
  assign past_end       = ram_a > tape_end;
  assign sync_win       = cnt < SYNC_END;
  assign data_win       = (cnt > DATA_AT) && (cnt < DATA_END) && bitval;
  assign latch_set      = (state == ST_RUN) & ~past_end & ~motor_on_edge & ~motor_off_edge
                          & (sync_win | data_win);
  assign latch_clr      = wr_stb | rd_stb;

  // While playing, the audio mix follows the conditioned tape bit instead of the CPU value.
  assign snd = busy ? {1'b0, latch} : snd_wr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 12'd0;
      bitptr <= BITPTR_MSB;
      ram_a  <= 17'd0;
      latch  <= 1'b0;
      bitval <= 1'b0;
      motor  <= 1'b0;
      snd_wr <= 2'b00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (ce) begin
      if (wr_stb) begin
        motor  <= port_d[2];
        snd_wr <= port_d[1:0];
      end

      if (latch_set)      latch <= 1'b1;
      else if (latch_clr) latch <= 1'b0;

      // Motor edges override whatever the state machine would otherwise do this ce.
      if (motor_off_edge) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        cnt   <= 12'd0;
      end else if (motor_on_edge) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        cnt    <= 12'd0;
        ram_a  <= 17'd0;
        bitptr <= BITPTR_MSB;
      end else begin
        case (state)
          ST_IDLE: begin
            if (play || (rd_stb && motor)) begin
              state  <= ST_RUN;
              busy   <= 1'b1;
              ram_a  <= 17'd0;
              bitptr <= BITPTR_MSB;
              cnt    <= 12'd0;
              done   <= 1'b0;
            end
          end
          ST_RUN: begin
            if (past_end) begin
              state <= ST_STOP;
              busy  <= 1'b0;
              done  <= 1'b1;
              latch <= 1'b0;
            end else begin
              cnt <= (cnt >= PERIOD) ? 12'd0 : cnt + 12'd1;
              // ram_a has been stable since the previous bit boundary, so ram_q is valid here.
              if (cnt == DATA_AT) begin
                bitval <= byte_bit(ram_q, bitptr);
                if (bitptr == 3'd0) begin
                  bitptr <= BITPTR_MSB;
                  ram_a  <= ram_a + 17'd1;
                end else begin
                  bitptr <= bitptr - 3'd1;
                end
              end
            end
          end
          ST_STOP: begin
            latch <= 1'b0;
            if (!play) state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player: single-ce vector table plus long playback, port-clear, motor and reset sequences.
module tb_cas_player;
  import cg_tape_pkg::*;

  localparam int CELL = int'(PERIOD_DEF) + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        play = 1'b0;
  logic        port_wr = 1'b0;
  logic [2:0]  port_d = 3'b000;
  logic        port_rd = 1'b0;
  logic [16:0] tape_end = 17'd0;
  logic [16:0] ram_a;
  logic [7:0]  ram_q = 8'h00;
  logic        latch, motor, busy, done;
  logic [1:0]  snd;
  tape_state_t state;

  logic [7:0] mem [0:3];
  int checks = 0;
  int failures = 0;
  int t = 0;

  cas_player dut (
    .clock(clock), .reset(reset), .ce(ce), .play(play),
    .port_wr(port_wr), .port_d(port_d), .port_rd(port_rd),
    .tape_end(tape_end), .ram_a(ram_a), .ram_q(ram_q),
    .latch(latch), .motor(motor), .snd(snd), .busy(busy), .done(done),
    .state(state)
  );

  always #5 clock = ~clock;

  // External CAS RAM: one clock read latency.
  always @(posedge clock) ram_q <= mem[ram_a[1:0]];

  typedef struct {
    logic       ce;
    logic       play;
    logic       wr;
    logic [2:0] d;
    logic       rd;
    logic [1:0] st;
    logic       motor;
    logic [1:0] snd;
    logic       busy;
    logic       latch;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic wr, input logic [2:0] d, input logic rd);
    @(negedge clock);
    ce = c; port_wr = wr; port_d = d; port_rd = rd;
    @(posedge clock);
    #1;
    ce = 1'b0; port_wr = 1'b0; port_rd = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'b000, 1'b0);
    t += n;
  endtask

  task automatic go_to(input int target);
    steps(target - t);
  endtask

  task automatic rd_ce();
    cyc(1'b1, 1'b0, 3'b000, 1'b1);
    t++;
  endtask

  task automatic do_reset();
    ce = 1'b0; play = 1'b0; port_wr = 1'b0; port_rd = 1'b0; port_d = 3'b000;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'd1, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b1};

    for (int i = 0; i < 4; i++) mem[i] = 8'h00;

    do_reset();
    #1;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_latch", 32'(latch), 32'd0);
    check("rst_motor", 32'(motor), 32'd0);
    check("rst_snd",   32'(snd),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);

    // Single-ce vectors from reset: strobes, motor edges, priorities, ce gating.
    for (int i = 0; i < 15; i++) begin
      play = vecs[i].play;
      cyc(vecs[i].ce, vecs[i].wr, vecs[i].d, vecs[i].rd);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_motor", i), 32'(motor), 32'(vecs[i].motor));
      check($sformatf("vec%0d_snd", i),   32'(snd),   32'(vecs[i].snd));
      check($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].busy));
      check($sformatf("vec%0d_latch", i), 32'(latch), 32'(vecs[i].latch));
      check($sformatf("vec%0d_done", i),  32'(done),  32'd0);
      check($sformatf("vec%0d_ram_a", i), 32'(ram_a), 32'd0);
    end

    // Single byte 8'h80, tape_end=0, play held high throughout.
    do_reset();
    mem[0] = 8'h80;
    tape_end = 17'd0;
    play = 1'b1;
    cyc(1'b1, 1'b0, 3'b000, 1'b0);
    check("a_start_busy", 32'(busy), 32'd1);
    t = 0;
    steps(1);
    check("a_sync_first", 32'(latch), 32'd1);
    go_to(12'h1FF);
    rd_ce();
    check("a_sync_last_rd", 32'(latch), 32'd1);
    rd_ce();
    check("a_after_sync_rd", 32'(latch), 32'd0);
    go_to(12'h700);
    check("a_before_data", 32'(latch), 32'd0);
    steps(1);
    check("a_data_bit7", 32'(latch), 32'd1);
    go_to(12'h8FE);
    rd_ce();
    check("a_data_last_rd", 32'(latch), 32'd1);
    rd_ce();
    check("a_data_end_rd", 32'(latch), 32'd0);
    go_to(CELL + 12'h200);
    rd_ce();
    check("a_cell1_sync_rd", 32'(latch), 32'd0);
    go_to(CELL + 12'h900);
    check("a_bit6_zero", 32'(latch), 32'd0);
    go_to(7 * CELL + 12'h6FF);
    check("a_last_bit_ram_a", 32'(ram_a), 32'd0);
    steps(1);
    check("a_ram_a_inc", 32'(ram_a), 32'd1);
    check("a_still_run", 32'(state), 32'(ST_RUN));
    steps(1);
    check("a_stop_state", 32'(state), 32'(ST_STOP));
    check("a_stop_done", 32'(done), 32'd1);
    check("a_stop_busy", 32'(busy), 32'd0);
    check("a_stop_latch", 32'(latch), 32'd0);
    repeat (3) cyc(1'b1, 1'b0, 3'b000, 1'b0);
    check("a_no_retrigger", 32'(state), 32'(ST_STOP));
    play = 1'b0;
    cyc(1'b1, 1'b0, 3'b000, 1'b0);
    check("a_idle_after_play_low", 32'(state), 32'(ST_IDLE));
    check("a_done_sticky", 32'(done), 32'd1);
    play = 1'b1;
    cyc(1'b1, 1'b0, 3'b000, 1'b0);
    check("a_replay_busy", 32'(busy), 32'd1);
    check("a_replay_done", 32'(done), 32'd0);
    play = 1'b0;

    // Zero bytes, motor-started playback, port reads, motor edges, reset mid-run.
    do_reset();
    mem[0] = 8'h00;
    tape_end = 17'd5;
    cyc(1'b1, 1'b1, 3'b100, 1'b0);
    check("b_motor_on", 32'(motor), 32'd1);
    check("b_motor_on_idle", 32'(state), 32'(ST_IDLE));
    cyc(1'b1, 1'b0, 3'b000, 1'b1);
    check("b_rd_start", 32'(state), 32'(ST_RUN));
    t = 0;
    go_to(12'h100);
    rd_ce();
    check("b_rd_in_sync", 32'(latch), 32'd1);
    steps(1);
    check("b_rd_in_sync_next", 32'(latch), 32'd1);
    go_to(12'h300);
    rd_ce();
    check("b_rd_after_sync", 32'(latch), 32'd0);
    go_to(12'h900);
    check("b_no_data_latch", 32'(latch), 32'd0);
    go_to(CELL);
    check("b_quiet_to_cell_end", 32'(latch), 32'd0);
    steps(1);
    check("b_next_cell_sync", 32'(latch), 32'd1);
    go_to(8 * CELL + 12'h700);
    check("b_byte1_ram_a", 32'(ram_a), 32'd1);
    cyc(1'b1, 1'b1, 3'b000, 1'b0);
    check("b_motor_off_state", 32'(state), 32'(ST_IDLE));
    check("b_motor_off_keep_a", 32'(ram_a), 32'd1);
    check("b_motor_off_busy", 32'(busy), 32'd0);
    cyc(1'b1, 1'b1, 3'b100, 1'b0);
    check("b_motor_on_ram_a", 32'(ram_a), 32'd0);
    check("b_motor_on_state", 32'(state), 32'(ST_IDLE));
    cyc(1'b1, 1'b0, 3'b000, 1'b1);
    check("b_restart_state", 32'(state), 32'(ST_RUN));
    check("b_restart_ram_a", 32'(ram_a), 32'd0);
    t = 0;
    go_to(12'h150);
    check("b_pre_reset_latch", 32'(latch), 32'd1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("b_rst_latch", 32'(latch), 32'd0);
    check("b_rst_busy",  32'(busy),  32'd0);
    check("b_rst_motor", 32'(motor), 32'd0);
    check("b_rst_snd",   32'(snd),   32'd0);
    check("b_rst_state", 32'(state), 32'(ST_IDLE));
    #1 reset = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 3'b000, 1'b1);
    check("b_post_rst_idle", 32'(state), 32'(ST_IDLE));
    check("b_post_rst_latch", 32'(latch), 32'd0);
    check("b_post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
